// File: rtl/clk1_input_fifo.sv
// Input capture FIFO for the clk_1 domain: buffers {mode, CRC, message} beats
// in a first-word-fall-through queue and tracks occupancy and dropped beats.
module clk1_input_fifo #(
    parameter int pDATA_WIDTH  = 60,
    parameter int pMODE_WIDTH  = 1,
    parameter int pDEPTH       = 4,
    parameter int pAFULL_LEVEL = 3
) (
    input  logic                     clk_1,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [pMODE_WIDTH-1:0]   mode,
    input  logic                     CRC,
    input  logic [pDATA_WIDTH-1:0]   message,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [pMODE_WIDTH-1:0]   out_mode,
    output logic                     out_CRC,
    output logic [pDATA_WIDTH-1:0]   out_message,
    output logic [$clog2(pDEPTH):0]  level,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(pDEPTH);
    localparam int LW = AW + 1;
    localparam int EW = pMODE_WIDTH + 1 + pDATA_WIDTH;
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(pDEPTH);
    localparam logic [LW-1:0] AFULL_LEVEL = LW'(pAFULL_LEVEL);

    logic [EW-1:0]  mem_r [pDEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic           almost_full_r;
    logic           overflow_r;
    logic [7:0]     drop_cnt_r;

    logic           push_s;
    logic           pop_s;
    logic           drop_s;
    logic [LW-1:0]  level_nxt_s;
    logic           overflow_nxt_s;
    logic [7:0]     drop_base_s;
    logic [7:0]     drop_cnt_nxt_s;
    logic [EW-1:0]  head_s;

    // Readiness comes only from the registered level, so a pop never opens
    // space for a same-cycle push when the queue is full.
    assign in_ready  = (level_r != FULL_LEVEL);
    assign out_valid = (level_r != {LW{1'b0}});
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign drop_s    = in_valid && !in_ready;

    // Next occupancy, overflow flag and saturating drop count.
    always_comb begin
        level_nxt_s    = level_r;
        overflow_nxt_s = overflow_r;
        drop_base_s    = drop_cnt_r;
        drop_cnt_nxt_s = drop_cnt_r;

        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase

        if (clr_ovf) begin
            drop_base_s = 8'd0;
        end else begin
            drop_base_s = drop_cnt_r;
        end

        if (drop_s) begin
            overflow_nxt_s = 1'b1;
            drop_cnt_nxt_s = (drop_base_s == 8'hFF) ? drop_base_s : drop_base_s + 8'd1;
        end else if (clr_ovf) begin
            overflow_nxt_s = 1'b0;
            drop_cnt_nxt_s = 8'd0;
        end else begin
            overflow_nxt_s = overflow_r;
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Storage, pointers and status registers.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < pDEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            level_r       <= {LW{1'b0}};
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
            drop_cnt_r    <= 8'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {mode, CRC, message};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r       <= level_nxt_s;
            almost_full_r <= (level_nxt_s >= AFULL_LEVEL);
            overflow_r    <= overflow_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
        end
    end

    // Head entry falls through; when empty it shows the stale slot at rd_ptr.
    assign head_s = mem_r[rd_ptr_r];
    assign {out_mode, out_CRC, out_message} = head_s;

    assign level       = level_r;
    assign almost_full = almost_full_r;
    assign overflow    = overflow_r;
    assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_clk1_input_fifo.sv
// Self-checking bench for clk1_input_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_clk1_input_fifo;

    localparam int DW = 60;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam logic [59:0] MSG1 = 60'h0AB_CDEF_0123_4567;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [0:0]  mode = 1'b0;
    logic        CRC = 1'b0;
    logic [59:0] message = 60'd0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [0:0]  out_mode;
    logic        out_CRC;
    logic [59:0] out_message;
    logic [2:0]  level;
    logic        almost_full;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_ovf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    clk1_input_fifo #(
        .pDATA_WIDTH(DW), .pMODE_WIDTH(1), .pDEPTH(DEPTH), .pAFULL_LEVEL(AFULL)
    ) dut (
        .clk_1(clk_1), .rst(rst), .in_valid(in_valid), .mode(mode), .CRC(CRC),
        .message(message), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_mode(out_mode), .out_CRC(out_CRC),
        .out_message(out_message), .level(level), .almost_full(almost_full),
        .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk_1 = ~clk_1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {mode, CRC, message} plus drop bookkeeping.
    logic [61:0] mq[$];
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;

    always @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            bit full, do_push, do_pop, do_drop;
            full    = (mq.size() == DEPTH);
            do_push = in_valid && !full;
            do_drop = in_valid && full;
            do_pop  = (mq.size() != 0) && out_ready;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({mode, CRC, message});
            if (do_drop) begin
                m_ovf = 1'b1;
                m_cnt = clr_ovf ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
            end else if (clr_ovf) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_1) begin
        if ($time > 0) begin
            chk("in_ready",    64'(in_ready),    64'(mq.size() != DEPTH));
            chk("out_valid",   64'(out_valid),   64'(mq.size() != 0));
            chk("level",       64'(level),       64'(mq.size()));
            chk("almost_full", 64'(almost_full), 64'(mq.size() >= AFULL));
            chk("overflow",    64'(overflow),    64'(m_ovf));
            chk("drop_cnt",    64'(drop_cnt),    64'(m_cnt));
            if (mq.size() != 0) begin
                chk("payload", 64'({out_mode, out_CRC, out_message}), 64'(mq[0]));
            end
        end
    end

    // Drive one cycle of inputs at a negedge and return at the next negedge.
    task automatic drive(input bit iv, input int val, input bit ordy, input bit clr);
        in_valid  = iv;
        mode      = 1'(val);
        CRC       = 1'(val >> 1);
        message   = 60'(val);
        out_ready = ordy;
        clr_ovf   = clr;
        @(negedge clk_1);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk_1);
        @(negedge clk_1);
        rst = 1'b0;
        @(negedge clk_1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_out_message", 64'(out_message), 64'd0);

        // Single beat with an explicit payload.
        in_valid = 1'b1; mode = 1'b1; CRC = 1'b1; message = MSG1;
        out_ready = 1'b0; clr_ovf = 1'b0;
        @(negedge clk_1);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_msg", 64'(out_message), 64'(MSG1));
        chk("single_mode_crc", 64'({out_mode, out_CRC}), 64'd3);
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("single_level_after_pop", 64'(level), 64'd0);

        // Fill past capacity, then drain in order.
        for (int i = 1; i <= 6; i++) drive(1'b1, i, 1'b0, 1'b0);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_afull", 64'(almost_full), 64'd1);
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_drops", 64'(drop_cnt), 64'd2);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 64'(out_message), 64'(i));
            drive(1'b0, 0, 1'b1, 1'b0);
        end
        chk("drain_level", 64'(level), 64'd0);
        drive(1'b0, 0, 1'b0, 1'b1);

        // Streaming: 20 beats at one per cycle, pointers wrap repeatedly.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 100 + i, 1'b1, 1'b0);
            chk("stream_level", 64'(level), 64'd1);
            chk("stream_msg", 64'(out_message), 64'(100 + i));
        end
        chk("stream_drops", 64'(drop_cnt), 64'd0);
        drive(1'b0, 0, 1'b1, 1'b0);

        // Backpressure from level 2 with out_ready toggling.
        drive(1'b1, 200, 1'b0, 1'b0);
        drive(1'b1, 201, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, 202 + i, (i % 2) == 0, 1'b0);
        chk("bp_level", 64'(level), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        // Full + pop + in_valid: pop happens, beat dropped, space opens.
        drive(1'b1, 250, 1'b1, 1'b0);
        chk("full_pop_level", 64'(level), 64'd3);
        chk("full_pop_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b1, 1'b0);
        chk("bp_drained", 64'(level), 64'd0);
        drive(1'b0, 0, 1'b1, 1'b1);

        // Saturation, clear alone, clear racing a drop.
        for (int i = 0; i < 4; i++) drive(1'b1, 300 + i, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b1, 7, 1'b0, 1'b0);
        chk("sat_cnt", 64'(drop_cnt), 64'd255);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_cnt", 64'(drop_cnt), 64'd0);
        drive(1'b1, 9, 1'b0, 1'b1);
        chk("clr_drop_ovf", 64'(overflow), 64'd1);
        chk("clr_drop_cnt", 64'(drop_cnt), 64'd1);

        // Asynchronous reset mid-operation at level 3.
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd3);
        in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk_1);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_payload", 64'({out_mode, out_CRC, out_message}), 64'd0);
        rst = 1'b0;
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_level", 64'(level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk1_input_fifo.md
# clk1_input_fifo

Parametrised successor to the clk_1 input capture stage. It accepts pattern beats (mode, CRC flag, message) on `in_valid` and buffers them in a pDEPTH-entry first-word-fall-through FIFO. It presents the beats downstream with a valid/ready handshake, so back-to-back inputs are no longer lost to single-register overwrite. It sits at the clk_1 domain boundary, ahead of the CRC/encode logic. It reports occupancy, almost-full, and sticky overflow with a saturating drop count.

## Interface
- pDATA_WIDTH, 60: message width in bits.
- pMODE_WIDTH, 1: mode field width (≥1).
- pDEPTH, 4: FIFO entries; power of 2, ≥2.
- pAFULL_LEVEL, 3: `almost_full` asserts when level ≥ this value (1..pDEPTH).
- clk_1  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- mode  in  pMODE_WIDTH  input mode field.
- CRC  in  1  input CRC-enable flag.
- message  in  pDATA_WIDTH  input message.
- in_ready  out  1  high when FIFO not full; beat accepted iff in_valid && in_ready.
- out_valid  out  1  head entry available.
- out_ready  in  1  downstream accepts head; pop iff out_valid && out_ready.
- out_mode  out  pMODE_WIDTH  head mode.
- out_CRC  out  1  head CRC flag.
- out_message  out  pDATA_WIDTH  head message.
- level  out  $clog2(pDEPTH)+1  current occupancy, 0..pDEPTH.
- almost_full  out  1  level ≥ pAFULL_LEVEL.
- overflow  out  1  sticky; set when a beat is dropped.
- drop_cnt  out  8  dropped-beat count, saturates at 255.
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt.

## Operation
- Storage: pDEPTH entries of {mode, CRC, message}. Read and write pointers are log2(pDEPTH) bits and wrap naturally. Level counter is a separate register.
- Push: in_valid && in_ready writes the beat at wr_ptr; wr_ptr+1.
- Pop: out_valid && out_ready advances rd_ptr+1.
- Level: push only → +1. Pop only → −1. Both → unchanged.
- in_ready = (level != pDEPTH). It is derived from the registered level, so a pop in the same cycle does not open space for a push when full.
- Drop: in_valid && !in_ready. The beat is discarded, overflow ← 1, drop_cnt ← min(drop_cnt+1, 255).
- clr_ovf: overflow ← 0, drop_cnt ← 0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- out_valid = (level != 0). Payload outputs are driven combinationally from mem[rd_ptr]. Payload is stable while out_valid && !out_ready.
- out_* payload is undefined-by-contract when out_valid=0, but is deterministic: it shows the stale entry at rd_ptr.
- Reset (async, any time, including mid-burst): pointers=0, level=0, all entries=0, overflow=0, drop_cnt=0. All buffered beats are discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_mode=0, out_CRC=0, out_message=0, level=0, almost_full=0, overflow=0, drop_cnt=0.
- Latency: beat accepted at edge N into an empty FIFO gives out_valid=1 and payload visible after edge N (cycle N+1). There is no combinational in→out pass-through.
- Throughput: 1 beat/cycle sustained when out_ready=1 and level ∈ [1, pDEPTH−1].
- level, almost_full, overflow, and drop_cnt are registered and update on the edge of the triggering event.
- Full + pop + in_valid in the same cycle: pop occurs, beat dropped, level becomes pDEPTH−1, in_ready=1 the next cycle.
- Empty + out_ready: no pop, no pointer change.
- Wrap-around: pointers roll from pDEPTH−1 to 0 with no bubble.

## Test plan
- Reset/idle: assert rst mid-operation with level=3 → all outputs at reset values next cycle; after release, in_ready=1, level=0.
- Single beat: in_valid one cycle with mode=1, CRC=1, message=60'h0AB_CDEF_0123_4567 → out_valid=1 one cycle later with identical payload; out_ready=1 pops it, level returns to 0.
- Fill and drain (pDEPTH=4): push 6 beats with values 1..6 and out_ready=0 → level=4, almost_full=1 from level 3, beats 5 and 6 dropped, overflow=1, drop_cnt=2; drain outputs 1,2,3,4 in order.
- Streaming wrap: 20 consecutive beats with out_ready=1 → level stays 1, outputs in order, no drops, pointers wrap 5 times.
- Backpressure: level=2, out_ready toggling 1/0 each cycle with continuous in_valid → payload stable while stalled, in_ready falls at level 4, order preserved.
- Counter saturation and clear: 300 dropped beats → drop_cnt=255; clr_ovf alone → 0/0; clr_ovf in the same cycle as a drop → overflow=1, drop_cnt=1.
